// File: rtl/pipe_ex_mem.sv
// EX/MEM pipeline register with branch resolution, registered redirect and one-slot wrong-path squash.
// Optional branch statistics counters are enabled by defining PIPE_EX_MEM_BR_STATS_EN.
module pipe_ex_mem #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic        ex_zero,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc_plus4,
  input  logic [31:0] ex_br_imm,
  input  logic [31:0] ex_rt_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_mem_to_reg,
  output logic        mem_valid,
  output logic [31:0] mem_alu_result,
  output logic [31:0] mem_rt_data,
  output logic [4:0]  mem_rd,
  output logic        mem_reg_write,
  output logic        mem_mem_read,
  output logic        mem_mem_write,
  output logic        mem_mem_to_reg,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic [31:0] br_cnt,
  output logic [31:0] br_taken_cnt
);

  typedef enum logic {NORMAL, SQUASH} state_t;

  state_t      state_reg;
  logic        valid_reg;
  logic [31:0] alu_reg;
  logic [31:0] rt_reg;
  logic [4:0]  rd_reg;
  logic [3:0]  ctrl_reg;
  logic        br_taken_reg;
  logic [31:0] br_target_reg;

  logic        taken_ex;
  logic [31:0] target_next;
  logic [3:0]  ex_ctrl;
  logic [3:0]  mem_ctrl;

  assign taken_ex    = ex_valid & ex_is_branch & ex_zero;
  // Immediate is in words; the add wraps modulo 2^32.
  assign target_next = ex_pc_plus4 + {ex_br_imm[29:0], 2'b00};
  assign ex_ctrl     = {ex_mem_to_reg, ex_mem_write, ex_mem_read, ex_reg_write};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= NORMAL;
      valid_reg     <= 1'b0;
      alu_reg       <= 32'h0;
      rt_reg        <= 32'h0;
      rd_reg        <= 5'h0;
      ctrl_reg      <= 4'h0;
      br_taken_reg  <= 1'b0;
      br_target_reg <= RESET_PC;
    end else if (flush) begin
      valid_reg    <= 1'b0;
      br_taken_reg <= 1'b0;
      state_reg    <= NORMAL;
    end else if (!stall) begin
      case (state_reg)
        NORMAL: begin
          valid_reg    <= ex_valid;
          alu_reg      <= ex_alu_result;
          rt_reg       <= ex_rt_data;
          rd_reg       <= ex_rd;
          ctrl_reg     <= ex_ctrl;
          br_taken_reg <= taken_ex;
          if (taken_ex) begin
            br_target_reg <= target_next;
            state_reg     <= SQUASH;
          end
        end
        SQUASH: begin
          // The instruction now in EX was fetched down the wrong path.
          valid_reg    <= 1'b0;
          br_taken_reg <= 1'b0;
          ctrl_reg     <= 4'h0;
          state_reg    <= NORMAL;
        end
        default: state_reg <= NORMAL;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ctrl_gate
      assign mem_ctrl[gi] = ctrl_reg[gi] & valid_reg;
    end
  endgenerate

  assign mem_valid      = valid_reg;
  assign mem_alu_result = alu_reg;
  assign mem_rt_data    = rt_reg;
  assign mem_rd         = rd_reg;
  assign mem_reg_write  = mem_ctrl[0];
  assign mem_mem_read   = mem_ctrl[1];
  assign mem_mem_write  = mem_ctrl[2];
  assign mem_mem_to_reg = mem_ctrl[3];
  assign br_taken       = br_taken_reg;
  assign br_target      = br_target_reg;

`ifdef PIPE_EX_MEM_BR_STATS_EN
  logic [31:0] br_cnt_reg;
  logic [31:0] br_taken_cnt_reg;
  logic        count_en;

  assign count_en = !flush && !stall && (state_reg == NORMAL) && ex_valid && ex_is_branch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_reg       <= 32'h0;
      br_taken_cnt_reg <= 32'h0;
    end else if (count_en) begin
      br_cnt_reg <= br_cnt_reg + 32'd1;
      if (ex_zero) br_taken_cnt_reg <= br_taken_cnt_reg + 32'd1;
    end
  end

  assign br_cnt       = br_cnt_reg;
  assign br_taken_cnt = br_taken_cnt_reg;
`else
  assign br_cnt       = 32'h0;
  assign br_taken_cnt = 32'h0;
`endif

endmodule
